// File: rtl/vga_pkg.sv
// Shared frame constants, widths and types for the VRAM rectangle filler.
package vga_pkg;
    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;
    localparam int ADDR_W = 19;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int PIX_W  = 12;

    typedef logic [PIX_W-1:0] pixel_t;  // RGB444

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Clipped rectangle: exclusive end bounds plus the first row's base address.
    typedef struct packed {
        logic [X_W:0]      xe;
        logic [Y_W:0]      ye;
        logic              empty;
        logic [ADDR_W-1:0] row_base;
    } clip_t;
endpackage

// File: rtl/rect_clip.sv
// Combinational clip of a requested rectangle to the frame, plus y0*width
// formed from constant shifts and adds.
module rect_clip
    import vga_pkg::*;
#(
    parameter int width  = WIDTH,
    parameter int height = HEIGHT
) (
    input  logic [X_W-1:0] i_x0,
    input  logic [Y_W-1:0] i_y0,
    input  logic [X_W-1:0] i_w,
    input  logic [Y_W-1:0] i_h,
    output clip_t          o_clip
);
    localparam logic [X_W:0]      W_LIM = (X_W+1)'(width);
    localparam logic [Y_W:0]      H_LIM = (Y_W+1)'(height);
    localparam logic [ADDR_W-1:0] W_MUL = ADDR_W'(width);

    logic [X_W:0]      w_xsum;
    logic [Y_W:0]      w_ysum;
    logic [X_W:0]      w_xe;
    logic [Y_W:0]      w_ye;
    logic [ADDR_W-1:0] w_acc;

    always_comb begin
        // One extra bit keeps x0+w and y0+h from wrapping before the clip.
        w_xsum = {1'b0, i_x0} + {1'b0, i_w};
        w_ysum = {1'b0, i_y0} + {1'b0, i_h};
        w_xe   = (w_xsum > W_LIM) ? W_LIM : w_xsum;
        w_ye   = (w_ysum > H_LIM) ? H_LIM : w_ysum;

        w_acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (W_MUL[i]) w_acc = w_acc + (ADDR_W'(i_y0) << i);
        end

        o_clip.xe       = w_xe;
        o_clip.ye       = w_ye;
        o_clip.empty    = ({1'b0, i_x0} >= w_xe) || ({1'b0, i_y0} >= w_ye);
        o_clip.row_base = w_acc;
    end
endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: one VRAM write per cycle in raster order, with the
// address walked incrementally from a per-row base.
module vram_rect_fill
    import vga_pkg::*;
#(
    parameter int width  = WIDTH,
    parameter int height = HEIGHT
) (
    input  logic              vram_clk,
    input  logic              clrn,
    input  logic              start,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    h,
    input  pixel_t            color,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output pixel_t            data,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] W_MUL = ADDR_W'(width);

    state_t            r_state;
    logic [X_W-1:0]    r_col;
    logic [X_W-1:0]    r_x0;
    logic [X_W:0]      r_xe;
    logic [Y_W-1:0]    r_row;
    logic [Y_W:0]      r_ye;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    pixel_t            r_data;
    logic              r_busy;
    logic              r_done;

    clip_t             w_clip;
    logic [X_W:0]      w_col_nxt;
    logic [Y_W:0]      w_row_nxt;
    logic [ADDR_W-1:0] w_base_nxt;
    logic              w_row_end;
    logic              w_last;

    rect_clip #(.width(width), .height(height)) u_clip (
        .i_x0   (x0),
        .i_y0   (y0),
        .i_w    (w),
        .i_h    (h),
        .o_clip (w_clip)
    );

    // r_col/r_row always name the pixel currently presented on addr.
    always_comb begin
        w_col_nxt  = {1'b0, r_col} + (X_W+1)'(1);
        w_row_nxt  = {1'b0, r_row} + (Y_W+1)'(1);
        w_base_nxt = r_row_base + W_MUL;
        w_row_end  = (w_col_nxt == r_xe);
        w_last     = w_row_end && (w_row_nxt == r_ye);
    end

    always_ff @(posedge vram_clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_x0       <= '0;
            r_xe       <= '0;
            r_row      <= '0;
            r_ye       <= '0;
            r_row_base <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_clip.empty) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // First write goes out right away, from the clip outputs.
                            r_state    <= S_FILL;
                            r_we       <= 1'b1;
                            r_addr     <= w_clip.row_base + ADDR_W'(x0);
                            r_data     <= color;
                            r_col      <= x0;
                            r_x0       <= x0;
                            r_xe       <= w_clip.xe;
                            r_row      <= y0;
                            r_ye       <= w_clip.ye;
                            r_row_base <= w_clip.row_base;
                        end
                    end
                end
                S_FILL: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_row_end) begin
                        r_row      <= w_row_nxt[Y_W-1:0];
                        r_col      <= r_x0;
                        r_row_base <= w_base_nxt;
                        r_addr     <= w_base_nxt + ADDR_W'(r_x0);
                    end else begin
                        r_col  <= w_col_nxt[X_W-1:0];
                        r_addr <= r_row_base + ADDR_W'(w_col_nxt);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign we   = r_we;
    assign addr = r_addr;
    assign data = r_data;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed bench for vram_rect_fill: raster writes, clipping, empty requests,
// ignored restarts and asynchronous reset mid-fill.
module tb_vram_rect_fill;
    logic        vram_clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  w;
    logic [8:0]  h;
    logic [11:0] color;
    logic        we;
    logic [18:0] addr;
    logic [11:0] data;
    logic        busy;
    logic        done;

    int n_err    = 0;
    int n_checks = 0;

    vram_rect_fill dut (
        .vram_clk (vram_clk),
        .clrn     (clrn),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .color    (color),
        .we       (we),
        .addr     (addr),
        .data     (data),
        .busy     (busy),
        .done     (done)
    );

    always #5 vram_clk = ~vram_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle and settle just after the edge.
    task automatic tick();
        @(posedge vram_clk);
        #1;
    endtask

    // Pulse start for one rectangle and check every cycle of the response.
    // The bench's own frame model uses a plain y*640+x address.
    task automatic do_fill(input string tag, input logic [9:0] fx, input logic [8:0] fy,
                           input logic [9:0] fw, input logic [8:0] fh,
                           input logic [11:0] fc, input bit repulse);
        int xe, ye, n, exp_addr;
        logic [31:0] prev_addr;
        prev_addr = 32'(addr);
        xe = (int'(fx) + int'(fw) > 640) ? 640 : int'(fx) + int'(fw);
        ye = (int'(fy) + int'(fh) > 480) ? 480 : int'(fy) + int'(fh);
        n  = (int'(fx) >= xe || int'(fy) >= ye) ? 0 : (xe - int'(fx)) * (ye - int'(fy));
        x0 = fx; y0 = fy; w = fw; h = fh; color = fc; start = 1'b1;
        tick();
        // Scramble the request inputs; the latched rectangle must not move.
        x0 = ~fx; y0 = ~fy; w = ~fw; h = ~fh; color = ~fc;
        start = repulse;
        if (n == 0) begin
            chk({tag, ".empty_we"},   32'(we),   32'd0);
            chk({tag, ".empty_done"}, 32'(done), 32'd1);
            chk({tag, ".empty_busy"}, 32'(busy), 32'd1);
            chk({tag, ".empty_addr"}, 32'(addr), prev_addr);
            start = 1'b0;
            tick();
            chk({tag, ".empty_busy2"}, 32'(busy), 32'd0);
            chk({tag, ".empty_done2"}, 32'(done), 32'd0);
            return;
        end
        for (int yy = int'(fy); yy < ye; yy++) begin
            for (int xx = int'(fx); xx < xe; xx++) begin
                exp_addr = yy * 640 + xx;
                chk({tag, ".we"},   32'(we),   32'd1);
                chk({tag, ".addr"}, 32'(addr), 32'(exp_addr));
                chk({tag, ".data"}, 32'(data), 32'(fc));
                chk({tag, ".done"}, 32'(done), 32'd0);
                chk({tag, ".busy"}, 32'(busy), 32'd1);
                tick();
            end
        end
        chk({tag, ".end_we"},   32'(we),   32'd0);
        chk({tag, ".end_done"}, 32'(done), 32'd1);
        chk({tag, ".end_busy"}, 32'(busy), 32'd1);
        chk({tag, ".end_addr"}, 32'(addr), 32'((ye - 1) * 640 + xe - 1));
        chk({tag, ".end_data"}, 32'(data), 32'(fc));
        start = 1'b0;
        tick();
        chk({tag, ".idle_done"}, 32'(done), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".idle_we"},   32'(we),   32'd0);
    endtask

    int nwr;

    initial begin
        clrn = 1'b0; start = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
        #2;
        chk("rst.we",   32'(we),   32'd0);
        chk("rst.addr", 32'(addr), 32'd0);
        chk("rst.data", 32'(data), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        tick();
        clrn = 1'b1;
        tick();
        tick();
        chk("idle.busy", 32'(busy), 32'd0);

        // 2x2 at origin: addr 0,1,640,641 then done at k+5.
        do_fill("sq2", 10'd0, 9'd0, 10'd2, 9'd2, 12'hF00, 1'b0);
        // Accepted the cycle after done returns to IDLE: clipped corner.
        do_fill("clip", 10'd638, 9'd479, 10'd4, 9'd3, 12'h0F0, 1'b0);
        do_fill("offx", 10'd700, 9'd10, 10'd5, 9'd5, 12'h00F, 1'b0);
        do_fill("w0",   10'd10, 9'd10, 10'd0, 9'd5, 12'h123, 1'b0);
        do_fill("offy", 10'd10, 9'd480, 10'd5, 9'd5, 12'h456, 1'b0);
        do_fill("mid",  10'd5, 9'd300, 10'd3, 9'd2, 12'hA5A, 1'b0);
        // start held with a different color throughout a 10x10 fill.
        do_fill("rep",  10'd100, 9'd200, 10'd10, 9'd10, 12'h3C7, 1'b1);

        // 4x4 fill aborted by reset in its fifth write cycle.
        x0 = 10'd20; y0 = 9'd20; w = 10'd4; h = 9'd4; color = 12'hBEE; start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort.first", 32'(addr), 32'(20 * 640 + 20));
        tick(); tick(); tick(); tick();
        chk("abort.c5_addr", 32'(addr), 32'(21 * 640 + 20));
        clrn = 1'b0;
        #1;
        chk("abort.we",   32'(we),   32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.addr", 32'(addr), 32'd0);
        chk("abort.data", 32'(data), 32'd0);
        tick();
        clrn = 1'b1;
        nwr = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (we) nwr++;
        end
        chk("abort.no_writes", 32'(nwr), 32'd0);
        chk("abort.idle_busy", 32'(busy), 32'd0);
        do_fill("px", 10'd3, 9'd2, 10'd1, 9'd1, 12'hABC, 1'b0);
        chk("px.addr_held", 32'(addr), 32'd1283);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
